// File: rtl/pp_reduction_pipe_if.sv
// Handshake bundle between the 3x3 partial-product generator and its reduction pipe.
// The slave side is the reduction pipe and the master side is the producer/consumer.
interface pp_reduction_pipe_if #(
    parameter int COUNT_W = 8
);
    logic               in_valid;
    logic               in_ready;
    logic               a0b0;
    logic               a0b1;
    logic               a0b2;
    logic               a1b0;
    logic               a1b1;
    logic               a1b2;
    logic               a2b0;
    logic               a2b1;
    logic               a2b2;
    logic               out_valid;
    logic               out_ready;
    logic [5:0]         product;
    logic               busy;
    logic [COUNT_W-1:0] done_count;

    modport master (
        output in_valid, a0b0, a0b1, a0b2, a1b0, a1b1, a1b2, a2b0, a2b1, a2b2, out_ready,
        input  in_ready, out_valid, product, busy, done_count
    );

    modport slave (
        input  in_valid, a0b0, a0b1, a0b2, a1b0, a1b1, a1b2, a2b0, a2b1, a2b2, out_ready,
        output in_ready, out_valid, product, busy, done_count
    );
endinterface

// File: rtl/pp_reduction_pipe.sv
// Reduces nine 3x3 partial products to a 6-bit product in two stages:
// carry-save compression, then a carry-propagate add, with valid/ready on both sides.
module pp_reduction_pipe #(
    parameter int COUNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    pp_reduction_pipe_if.slave bus
);

    function automatic logic maj3(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

    logic               r_v1;
    logic               r_v2;
    logic [4:0]         r_s;
    logic [4:0]         r_c;
    logic [5:0]         r_product;
    logic [COUNT_W-1:0] r_done_count;

    logic               w_adv1;
    logic               w_adv2;
    logic               w_xfer;
    logic [4:0]         w_s;
    logic [4:0]         w_c;

    // Full adder on weight 2, half adders on weights 1 and 3; S + C equals a*b.
    assign w_s = {bus.a2b2,
                  bus.a1b2 ^ bus.a2b1,
                  bus.a0b2 ^ bus.a1b1 ^ bus.a2b0,
                  bus.a0b1 ^ bus.a1b0,
                  bus.a0b0};
    assign w_c = {bus.a1b2 & bus.a2b1,
                  maj3(bus.a0b2, bus.a1b1, bus.a2b0),
                  bus.a0b1 & bus.a1b0,
                  2'b00};

    // An empty stage always advances, so bubbles collapse even with out_ready low.
    assign w_adv2 = !r_v2 || bus.out_ready;
    assign w_adv1 = !r_v1 || w_adv2;
    assign w_xfer = r_v2 && bus.out_ready;

    // Pipeline registers and completed-transfer counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v1         <= 1'b0;
            r_v2         <= 1'b0;
            r_s          <= 5'd0;
            r_c          <= 5'd0;
            r_product    <= 6'd0;
            r_done_count <= '0;
        end else begin
            if (w_adv2) begin
                r_v2 <= r_v1;
                if (r_v1) begin
                    r_product <= {1'b0, r_s} + {1'b0, r_c};
                end
            end
            if (w_adv1) begin
                r_v1 <= bus.in_valid;
                if (bus.in_valid) begin
                    r_s <= w_s;
                    r_c <= w_c;
                end
            end
            if (w_xfer) begin
                r_done_count <= r_done_count + {{(COUNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign bus.in_ready   = w_adv1;
    assign bus.out_valid  = r_v2;
    assign bus.product    = r_product;
    assign bus.busy       = r_v1 || r_v2;
    assign bus.done_count = r_done_count;

endmodule

// File: tb/tb_pp_reduction_pipe.sv
// Directed bench for pp_reduction_pipe: expected products are queued on input
// handshakes and compared in order on output handshakes.
module tb_pp_reduction_pipe;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    pp_reduction_pipe_if #(.COUNT_W(8)) bus ();
    pp_reduction_pipe_if #(.COUNT_W(2)) bus2 ();

    pp_reduction_pipe #(.COUNT_W(8)) dut  (.clk(clk), .rst(rst), .bus(bus.slave));
    pp_reduction_pipe #(.COUNT_W(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

    int         tests = 0;
    int         fails = 0;
    logic [5:0] sb_q[$];
    logic [5:0] cur_exp;
    int         acc = 0;
    int         outs = 0;
    int         model_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Ordered {a2b2,a2b1,a2b0,a1b2,a1b1,a1b0,a0b2,a0b1,a0b0}
    function automatic logic [8:0] pp_of(input logic [2:0] a, input logic [2:0] b);
        return {a[2] & b[2], a[2] & b[1], a[2] & b[0],
                a[1] & b[2], a[1] & b[1], a[1] & b[0],
                a[0] & b[2], a[0] & b[1], a[0] & b[0]};
    endfunction

    task automatic set_pp(input logic [2:0] a, input logic [2:0] b, input logic v);
        {bus.a2b2, bus.a2b1, bus.a2b0, bus.a1b2, bus.a1b1, bus.a1b0,
         bus.a0b2, bus.a0b1, bus.a0b0} = pp_of(a, b);
        bus.in_valid = v;
        cur_exp = {3'b000, a} * {3'b000, b};
    endtask

    task automatic set_pp2(input logic [2:0] a, input logic [2:0] b, input logic v);
        {bus2.a2b2, bus2.a2b1, bus2.a2b0, bus2.a1b2, bus2.a1b1, bus2.a1b0,
         bus2.a0b2, bus2.a0b1, bus2.a0b0} = pp_of(a, b);
        bus2.in_valid = v;
    endtask

    // Sample both handshakes just before the edge, then move to 1ns after it.
    task automatic cycle();
        logic [5:0] exp;
        #2;
        if (bus.in_valid && bus.in_ready) begin
            sb_q.push_back(cur_exp);
            acc++;
        end
        if (bus.out_valid && bus.out_ready) begin
            check("output_has_expected", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                exp = sb_q.pop_front();
                check("product", 32'(bus.product), 32'(exp));
            end
            outs++;
            model_cnt++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag, input int budget);
        int n;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            cycle();
            n++;
        end
        check(tag, 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        int         acc0;
        int         outs0;
        int         n;
        int         nx;
        logic [2:0] ta[4];
        logic [2:0] tbv[4];
        logic [2:0] ra;
        logic [2:0] rb;
        logic       xfer;

        rst = 1'b1;
        set_pp(3'd0, 3'd0, 1'b0);
        bus.out_ready = 1'b0;
        set_pp2(3'd0, 3'd0, 1'b0);
        bus2.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;

        // Reset state
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_done_count", 32'(bus.done_count), 32'd0);
        check("rst_product", 32'(bus.product), 32'd0);

        // 1: single 3*5, two-cycle latency
        bus.out_ready = 1'b1;
        set_pp(3'd3, 3'd5, 1'b1);
        cycle();
        bus.in_valid = 1'b0;
        check("t1_busy_stage1", 32'(bus.busy), 32'd1);
        check("t1_not_yet_valid", 32'(bus.out_valid), 32'd0);
        cycle();
        check("t1_out_valid", 32'(bus.out_valid), 32'd1);
        check("t1_product", 32'(bus.product), 32'd15);
        cycle();
        check("t1_done_count", 32'(bus.done_count), 32'd1);
        check("t1_idle", 32'(bus.out_valid), 32'd0);

        // 2: all 64 pairs back-to-back
        outs0 = outs;
        for (int a = 0; a < 8; a++) begin
            for (int b = 0; b < 8; b++) begin
                set_pp(3'(a), 3'(b), 1'b1);
                check("t2_in_ready", 32'(bus.in_ready), 32'd1);
                cycle();
            end
        end
        bus.in_valid = 1'b0;
        cycle();
        cycle();
        check("t2_consecutive_outputs", 32'(outs - outs0), 32'd64);
        drain("t2_drain", 10);
        check("t2_done_count", 32'(bus.done_count), 32'd65);

        // 3: backpressure fills both stages, then release
        ta  = '{3'd2, 3'd7, 3'd5, 3'd6};
        tbv = '{3'd3, 3'd7, 3'd4, 3'd1};
        bus.out_ready = 1'b0;
        acc0 = acc;
        for (int i = 0; i < 4; i++) begin
            set_pp(ta[acc - acc0], tbv[acc - acc0], 1'b1);
            cycle();
        end
        check("t3_accepted", 32'(acc - acc0), 32'd2);
        check("t3_in_ready_low", 32'(bus.in_ready), 32'd0);
        check("t3_out_valid", 32'(bus.out_valid), 32'd1);
        check("t3_product_first", 32'(bus.product), 32'd6);
        cycle();
        check("t3_product_held", 32'(bus.product), 32'd6);
        check("t3_valid_held", 32'(bus.out_valid), 32'd1);
        bus.out_ready = 1'b1;
        n = 0;
        while (acc - acc0 < 4 && n < 20) begin
            set_pp(ta[acc - acc0], tbv[acc - acc0], 1'b1);
            cycle();
            n++;
        end
        check("t3_all_accepted", 32'(acc - acc0), 32'd4);
        drain("t3_drain", 10);

        // 4: out_ready toggling during a random stream
        acc0 = acc;
        ra = 3'($urandom_range(7));
        rb = 3'($urandom_range(7));
        nx = 0;
        while (acc - acc0 < 12 && nx < 80) begin
            bus.out_ready = nx[0];
            set_pp(ra, rb, 1'b1);
            n = acc;
            cycle();
            if (acc != n) begin
                ra = 3'($urandom_range(7));
                rb = 3'($urandom_range(7));
            end
            nx++;
        end
        check("t4_all_accepted", 32'(acc - acc0), 32'd12);
        drain("t4_drain", 10);
        check("t4_done_count", 32'(bus.done_count), 32'(model_cnt & 255));

        // 5: reset with both stages full
        bus.out_ready = 1'b0;
        set_pp(3'd1, 3'd1, 1'b1);
        cycle();
        set_pp(3'd2, 3'd2, 1'b1);
        cycle();
        bus.in_valid = 1'b0;
        check("t5_full_valid", 32'(bus.out_valid), 32'd1);
        check("t5_full_ready_low", 32'(bus.in_ready), 32'd0);
        rst = 1'b1;
        #1;
        check("t5_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("t5_rst_busy", 32'(bus.busy), 32'd0);
        check("t5_rst_done_count", 32'(bus.done_count), 32'd0);
        sb_q.delete();
        model_cnt = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("t5_no_output", 32'(bus.out_valid), 32'd0);
            cycle();
        end
        check("t5_count_after", 32'(bus.done_count), 32'd0);

        // 6: COUNT_W=2 wraps 1,2,3,0,1
        bus2.out_ready = 1'b1;
        n = 0;
        for (int k = 0; k < 10; k++) begin
            set_pp2(3'(k + 1), 3'd3, k < 5);
            #2;
            xfer = bus2.out_valid && bus2.out_ready;
            @(posedge clk);
            #1;
            if (xfer) begin
                n++;
                check("t6_done_count", 32'(bus2.done_count), 32'(n % 4));
            end
        end
        check("t6_transfers", 32'(n), 32'd5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
